// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int frameLen(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serial frame, with a decode of the final bit.
module piso_bit_counter #(
  parameter int CW        = 3,
  parameter int FRAME_LEN = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a back-to-back load restarts at bit zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, with valid/ready input handshake.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int FRAME_LEN = frameLen(WIDTH);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(FRAME_LEN - 2);

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shiftReg_q, shiftReg_d;
  logic                   sout_q, sout_d;
  logic                   soutValid_q, soutValid_d;
  logic                   frameDone_q, frameDone_d;
  logic                   busy_q, busy_d;

  logic [FRAME_LEN-1:0]   frameWord;
  logic                   accept;
  logic                   lastBit;
  logic [CW-1:0]          bitCount;
  logic                   cntLast;

`ifdef PISO_PARITY_EN
  assign frameWord = {^din, din};
`else
  assign frameWord = din;
`endif

  assign lastBit   = (state_q == SHIFT) && cntLast;
  assign din_ready = (state_q == IDLE) || lastBit;
  assign accept    = din_valid && din_ready;

  piso_bit_counter #(
    .CW        (CW),
    .FRAME_LEN (FRAME_LEN)
  ) u_bit_counter (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (accept || lastBit),
    .enable_i (state_q == SHIFT),
    .count_o  (bitCount),
    .last_o   (cntLast)
  );

  // Outputs are computed one cycle ahead so every output except din_ready is a flop.
  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    if (accept) begin
      state_d    = SHIFT;
      shiftReg_d = frameWord;
    end else if (state_q == SHIFT) begin
      shiftReg_d = shiftReg_q >> 1;
      if (cntLast) begin
        state_d = IDLE;
      end
    end
    soutValid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    sout_d      = (state_d == SHIFT) && shiftReg_d[0];
    frameDone_d = (state_q == SHIFT) && !accept && !cntLast && (bitCount == PENULT_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shiftReg_q  <= '0;
      sout_q      <= 1'b0;
      soutValid_q <= 1'b0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shiftReg_q  <= shiftReg_d;
      sout_q      <= sout_d;
      soutValid_q <= soutValid_d;
      frameDone_q <= frameDone_d;
      busy_q      <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = soutValid_q;
  assign frame_done = frameDone_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: hand-written vector tables plus
// randomized traffic checked against a queue-based frame model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         dinValid = 1'b0;
  logic         dinReady;
  logic         sout;
  logic         soutValid;
  logic         frameDone;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;

  logic         modelBits[$];
  logic [FL-1:0] sipo = '0;

  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic         expSout;
    logic         expSv;
    logic         expFd;
    logic         expRdy;
  } vec_t;

  vec_t vecs[$];

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (dinValid),
    .din_ready  (dinReady),
    .sout       (sout),
    .sout_valid (soutValid),
    .frame_done (frameDone),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream SIPO: shifts in LSB-first so the first bit ends at index 0.
  always @(posedge clk) begin
    if (soutValid) sipo <= {sout, sipo[FL-1:1]};
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the frame model at the edge, compare at negedge.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d);
    logic         mReady;
    logic [FL-1:0] frame;
    rst      = r;
    dinValid = v;
    din      = d;
    @(posedge clk);
    if (r) begin
      modelBits.delete();
    end else begin
      mReady = (modelBits.size() <= 1);
      if (modelBits.size() > 0) void'(modelBits.pop_front());
      if (v && mReady) begin
`ifdef PISO_PARITY_EN
        frame = {^d, d};
`else
        frame = d;
`endif
        for (int i = 0; i < FL; i++) modelBits.push_back(frame[i]);
      end
    end
    @(negedge clk);
    checkOutput("model_ready", dinReady,  modelBits.size() <= 1);
    checkOutput("model_valid", soutValid, modelBits.size() > 0);
    checkOutput("model_sout",  sout,      (modelBits.size() > 0) ? modelBits[0] : 1'b0);
    checkOutput("model_done",  frameDone, modelBits.size() == 1);
    checkOutput("model_busy",  busy,      modelBits.size() > 0);
  endtask

  task automatic addVec(input logic r, input logic v, input logic [W-1:0] d,
                        input logic s, input logic sv, input logic fd, input logic rdy);
    vec_t x;
    x = '{r, v, d, s, sv, fd, rdy};
    vecs.push_back(x);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("reset_ready", dinReady, 1'b1);
    checkOutput("reset_busy",  busy,     1'b0);
    checkOutput("reset_done",  frameDone, 1'b0);

`ifdef PISO_PARITY_EN
    // 4'b0111 -> 1,1,1,0 then parity 1 carrying frame_done
    addVec(0, 1, 4'h7, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 1, 1);
    addVec(0, 0, 4'h0, 0, 0, 0, 1);
`else
    // single word 4'b1011
    addVec(0, 1, 4'hB, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 1, 1);
    addVec(0, 0, 4'h0, 0, 0, 0, 1);
    // back-to-back 4'hA then 4'h5 held valid
    addVec(0, 1, 4'hA, 0, 1, 0, 0);
    addVec(0, 1, 4'h5, 1, 1, 0, 0);
    addVec(0, 1, 4'h5, 0, 1, 0, 0);
    addVec(0, 1, 4'h5, 1, 1, 1, 1);
    addVec(0, 1, 4'h5, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 1, 1);
    addVec(0, 0, 4'h0, 0, 0, 0, 1);
    // backpressure: 4'h3 held while 4'hC streams
    addVec(0, 1, 4'hC, 0, 1, 0, 0);
    addVec(0, 1, 4'h3, 0, 1, 0, 0);
    addVec(0, 1, 4'h3, 1, 1, 0, 0);
    addVec(0, 1, 4'h3, 1, 1, 1, 1);
    addVec(0, 1, 4'h3, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 0, 0);
    addVec(0, 0, 4'h0, 0, 1, 1, 1);
    addVec(0, 0, 4'h0, 0, 0, 0, 1);
`endif
    // mid-frame reset discards the frame; reset also beats a same-cycle accept
    addVec(0, 1, 4'hF, 1, 1, 0, 0);
    addVec(0, 0, 4'h0, 1, 1, 0, 0);
    addVec(1, 0, 4'h0, 0, 0, 0, 1);
    addVec(0, 0, 4'h0, 0, 0, 0, 1);
    addVec(1, 1, 4'h6, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].d);
      checkOutput("vec_sout",  sout,      vecs[i].expSout);
      checkOutput("vec_valid", soutValid, vecs[i].expSv);
      checkOutput("vec_done",  frameDone, vecs[i].expFd);
      checkOutput("vec_ready", dinReady,  vecs[i].expRdy);
    end

    // end-to-end through the SIPO
    applyStimulus(1'b0, 1'b1, 4'h9);
    repeat (FL) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < W; i++) begin
      checkOutput("sipo_bit", sipo[i], (i == 0) || (i == 3));
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-005 SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-006 SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-007 SHALL have port sout, output, 1 bit: the serial data bit, which drives the downstream shift register D input.
REQ-008 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-009 SHALL have port frame_done, output, 1 bit: a one-cycle pulse coincident with the last bit of a frame.
REQ-010 SHALL have port busy, output, 1 bit: the state machine is not IDLE.

Function
REQ-011 SHALL implement states IDLE and SHIFT only.
REQ-012 SHALL accept a word when din_valid && din_ready are both high at a rising edge; the transfer is "accepted".
REQ-013 SHALL drive din_ready=1 in IDLE and in the final bit cycle of SHIFT; din_ready SHALL be 0 otherwise.
REQ-014 SHALL, on acceptance, load din into the shift register, clear the bit counter, and enter or remain in SHIFT.
REQ-015 SHALL present din[0] on sout with sout_valid=1 in the cycle after acceptance (latency 1), sending the LSB first.
REQ-016 SHALL, in SHIFT, shift right by one bit per cycle and increment the bit counter, giving FRAME_LEN consecutive sout_valid cycles (FRAME_LEN=WIDTH unless REQ-025 applies).
REQ-017 SHALL assert frame_done in the cycle where the counter equals FRAME_LEN-1.
REQ-018 SHALL, in that final bit cycle, remain in SHIFT if a new word is accepted (zero-gap back-to-back frames), else return to IDLE.
REQ-019 SHALL ignore din_valid while din_ready=0; no word is captured or lost-accounted, and the upstream source holds its word.
REQ-020 SHALL drive sout=0 and sout_valid=0 in IDLE.
REQ-021 SHALL size the bit counter at $clog2(FRAME_LEN+1) bits; it SHALL never wrap inside a frame.
REQ-022 SHALL drive all outputs from registers, except din_ready, which is decoded from state and counter.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, frame_done=0 and busy=0; rst overrides a simultaneous acceptance.
REQ-024 SHALL, on reset mid-frame, discard the frame with no frame_done and return to IDLE; din_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-025 SHALL, with macro PISO_PARITY_EN defined, append one even-parity bit (XOR of the accepted word) after bit WIDTH-1, making FRAME_LEN=WIDTH+1, with frame_done on the parity bit.
REQ-026 SHALL, without PISO_PARITY_EN, have no parity logic and FRAME_LEN=WIDTH.

Structure
REQ-027 SHALL take the state enum (IDLE, SHIFT) and the default width constant from shared package piso_pkg.
REQ-028 SHALL implement the counter and last-bit decode as sub-module piso_bit_counter (inputs clear and enable; outputs count and last).

Verification (WIDTH=4)
REQ-029 SHALL verify single word: din=4'b1011 accepted at cycle 0 -> sout=1,1,0,1 in cycles 1-4, sout_valid=1 for 4 cycles, frame_done only in cycle 4, then IDLE.
REQ-030 SHALL verify back-to-back: 4'hA, then 4'h5 held valid -> 4'h5 accepted in cycle 4, sout=0,1,0,1,1,0,1,0 with no gap, and two frame_done pulses.
REQ-031 SHALL verify backpressure: din_valid held with 4'h3 while busy in cycles 1-3 -> din_ready=0, and the stream is unaffected until cycle 4.
REQ-032 SHALL verify mid-frame reset: rst=1 in cycle 2 -> cycle 3 shows sout_valid=0, frame_done never asserts, and din_ready=1.
REQ-033 SHALL verify parity with PISO_PARITY_EN defined: din=4'b0111 -> sout=1,1,1,0,1 (parity 1), with frame_done in cycle 5.
REQ-034 SHALL verify end-to-end: the serial output feeding a 4-bit SIPO, din=4'h9 -> the SIPO holds 4'h9 after frame_done.
